// File: rtl/rheed_multicrop_router_if.sv
`default_nettype none
//==============================================================================
// Module   : rheed_multicrop_router_if
// Purpose  : Stream bundle of the RHEED multi-crop router. It carries the wide
//            Mono8 input stream (s_axis_*) and the NUM_CROPS per-crop pixel
//            output streams (m_axis_*).
// Ports    : s_axis_tvalid/tready/tdata          - input beat stream
//            m_axis_tvalid/tready/tdata/tlast    - per-crop pixel streams
// Modports : master - environment view: sources beats, sinks crop pixels
//            slave  - router view: sinks beats, sources crop pixels
// Revision : 1.0 - initial release
//==============================================================================
interface rheed_multicrop_router_if #(
    parameter int NUM_CROPS   = 5,
    parameter int BEAT_PIXELS = 32
);
    logic                          s_axis_tvalid;
    logic                          s_axis_tready;
    logic [8*BEAT_PIXELS-1:0]      s_axis_tdata;
    logic [NUM_CROPS-1:0]          m_axis_tvalid;
    logic [NUM_CROPS-1:0]          m_axis_tready;
    logic [NUM_CROPS-1:0][7:0]     m_axis_tdata;
    logic [NUM_CROPS-1:0]          m_axis_tlast;

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface
`default_nettype wire

// File: rtl/rheed_multicrop_router.sv
`default_nettype none
//==============================================================================
// Module   : rheed_multicrop_router
// Purpose  : Serialises wide Mono8 beats to one pixel per cycle and routes each
//            pixel into NUM_CROPS independent crop windows, each with its own
//            FIFO, enable, legality check and end-of-window tlast.
// Ports    : clk, reset (async, active low)
//            ap_start/ap_idle/ap_done - frame control handshake
//            crop_en/crop_x0/crop_y0  - per-crop config, latched at ap_start
//            crop_err                 - per-crop window-outside-frame flag
//            axis (slave modport)     - input beats and per-crop outputs
//            crop_sum                 - per-crop pixel sum (CROP_SUM_EN only)
// Options  : define CROP_SUM_EN to add the crop_sum accumulators and port.
// Revision : 1.0 - initial release
//==============================================================================
module rheed_multicrop_router #(
    parameter int IN_ROWS     = 64,
    parameter int IN_COLS     = 64,
    parameter int OUT_ROWS    = 16,
    parameter int OUT_COLS    = 16,
    parameter int NUM_CROPS   = 5,
    parameter int BEAT_PIXELS = 32,
    parameter int FIFO_DEPTH  = 4,
    localparam int C_XW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1,
    localparam int C_YW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1
`ifdef CROP_SUM_EN
    , localparam int C_SW = 8 + $clog2(OUT_ROWS * OUT_COLS + 1)
`endif
) (
    input  wire logic                             clk,
    input  wire logic                             reset,
    input  wire logic                             ap_start,
    output logic                                  ap_idle,
    output logic                                  ap_done,
    input  wire logic [NUM_CROPS-1:0]             crop_en,
    input  wire logic [NUM_CROPS-1:0][C_XW-1:0]   crop_x0,
    input  wire logic [NUM_CROPS-1:0][C_YW-1:0]   crop_y0,
    output logic      [NUM_CROPS-1:0]             crop_err,
    rheed_multicrop_router_if.slave               axis
`ifdef CROP_SUM_EN
    , output logic    [NUM_CROPS-1:0][C_SW-1:0]   crop_sum
`endif
);
    localparam int               C_PW       = (BEAT_PIXELS > 1) ? $clog2(BEAT_PIXELS) : 1;
    localparam int               C_AW       = $clog2(FIFO_DEPTH);
    localparam logic [C_XW:0]    C_OC       = (C_XW+1)'(OUT_COLS);
    localparam logic [C_YW:0]    C_OR       = (C_YW+1)'(OUT_ROWS);
    localparam logic [C_XW:0]    C_IC       = (C_XW+1)'(IN_COLS);
    localparam logic [C_YW:0]    C_IR       = (C_YW+1)'(IN_ROWS);
    localparam logic [C_XW-1:0]  C_COL_LAST = C_XW'(IN_COLS - 1);
    localparam logic [C_YW-1:0]  C_ROW_LAST = C_YW'(IN_ROWS - 1);
    localparam logic [C_PW-1:0]  C_PIX_LAST = C_PW'(BEAT_PIXELS - 1);
    localparam logic [C_AW:0]    C_DEPTH    = (C_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                          r_state, w_state_nxt;
    logic [NUM_CROPS-1:0]            r_en, r_err;
    logic [NUM_CROPS-1:0][C_XW-1:0]  r_x0;
    logic [NUM_CROPS-1:0][C_YW-1:0]  r_y0;
    logic [8*BEAT_PIXELS-1:0]        r_beat;
    logic                            r_beat_vld;
    logic [C_PW-1:0]                 r_pix;
    logic [C_XW-1:0]                 r_col;
    logic [C_YW-1:0]                 r_row;

    logic                            w_start, w_advance, w_beat_done, w_frame_end;
    logic                            w_s_ready, w_accept;
    logic [7:0]                      w_pixel;
    logic [NUM_CROPS-1:0]            w_err_in, w_active, w_hit, w_last, w_full, w_empty;
    logic [NUM_CROPS-1:0]            w_m_valid, w_m_last;
    logic [NUM_CROPS-1:0][7:0]       w_m_data;

    assign w_start     = (r_state == S_IDLE) && ap_start;
    assign w_pixel     = r_beat[{r_pix, 3'b000} +: 8];
    assign w_frame_end = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);
    assign w_active    = r_en & ~r_err;
    // A pixel only waits on FIFOs it actually targets; other crops never stall.
    assign w_advance   = (r_state == S_RUN) && r_beat_vld && ~|(w_hit & w_full);
    assign w_beat_done = w_advance && (r_pix == C_PIX_LAST);
    // Refill in the same cycle the last pixel leaves, except at frame end.
    assign w_s_ready   = (r_state == S_RUN) && !(w_advance && w_frame_end) &&
                         (!r_beat_vld || w_beat_done);
    assign w_accept    = w_s_ready && axis.s_axis_tvalid;

    assign axis.s_axis_tready = w_s_ready;
    assign axis.m_axis_tvalid = w_m_valid;
    assign axis.m_axis_tdata  = w_m_data;
    assign axis.m_axis_tlast  = w_m_last;
    assign crop_err           = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) w_state_nxt = S_RUN;
            end
            S_RUN:   if (w_advance && w_frame_end) w_state_nxt = S_DRAIN;
            S_DRAIN: if (&w_empty) w_state_nxt = S_DONE;
            S_DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en       <= '0;
            r_err      <= '0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_beat     <= '0;
            r_beat_vld <= 1'b0;
            r_pix      <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_start) begin
            r_en       <= crop_en;
            r_err      <= w_err_in;
            r_x0       <= crop_x0;
            r_y0       <= crop_y0;
            r_beat_vld <= 1'b0;
            r_pix      <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else begin
            if (w_accept) begin
                r_beat     <= axis.s_axis_tdata;
                r_beat_vld <= 1'b1;
            end else if (w_beat_done) begin
                r_beat_vld <= 1'b0;
            end
            if (w_advance) begin
                r_pix <= (r_pix == C_PIX_LAST) ? '0 : r_pix + 1'b1;
                if (r_col == C_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CROPS; i++) begin : g_crop
        logic [C_XW:0]   w_xe;
        logic [C_YW:0]   w_ye;
        logic            w_wr, w_rd;
        logic [8:0]      r_mem [FIFO_DEPTH];
        logic [C_AW-1:0] r_wp, r_rp;
        logic [C_AW:0]   r_cnt;

        // One extra bit so a window running past the frame edge cannot wrap.
        assign w_err_in[i] = (({1'b0, crop_x0[i]} + C_OC) > C_IC) ||
                             (({1'b0, crop_y0[i]} + C_OR) > C_IR);
        assign w_xe     = {1'b0, r_x0[i]} + C_OC;
        assign w_ye     = {1'b0, r_y0[i]} + C_OR;
        assign w_hit[i] = w_active[i] &&
                          (r_col >= r_x0[i]) && ({1'b0, r_col} < w_xe) &&
                          (r_row >= r_y0[i]) && ({1'b0, r_row} < w_ye);
        assign w_last[i] = ({1'b0, r_col} == w_xe - 1'b1) &&
                           ({1'b0, r_row} == w_ye - 1'b1);

        assign w_full[i]    = (r_cnt == C_DEPTH);
        assign w_empty[i]   = (r_cnt == '0);
        assign w_wr         = w_advance && w_hit[i];
        assign w_rd         = !w_empty[i] && axis.m_axis_tready[i];
        assign w_m_valid[i] = !w_empty[i];
        // Gated so stale entries left by a mid-frame reset never leak out.
        assign w_m_data[i]  = w_empty[i] ? 8'h00 : r_mem[r_rp][7:0];
        assign w_m_last[i]  = !w_empty[i] && r_mem[r_rp][8];

        always_ff @(posedge clk) begin
            if (w_wr) r_mem[r_wp] <= {w_last[i], w_pixel};
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_wr) r_wp <= r_wp + 1'b1;
                if (w_rd) r_rp <= r_rp + 1'b1;
                case ({w_wr, w_rd})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

`ifdef CROP_SUM_EN
        logic [C_SW-1:0] r_sum;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sum <= '0;
            end else if (w_start) begin
                r_sum <= '0;
            end else if (w_wr) begin
                r_sum <= r_sum + C_SW'(w_pixel);
            end
        end
        assign crop_sum[i] = r_sum;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_rheed_multicrop_router.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_rheed_multicrop_router
// Purpose  : Self-checking bench for rheed_multicrop_router on an 8x32 frame
//            with three 4x4 crops. Expected crop streams come from a window
//            model over the frame pixel function; one negedge process compares
//            every handshake and every cycle's idle-crop/err outputs.
// Options  : CROP_SUM_EN also checks crop_sum.
// Revision : 1.0 - initial release
//==============================================================================
module tb_rheed_multicrop_router;
    localparam int IR = 8, IC = 32, OR_ = 4, OC = 4, NC = 3, BP = 32, FD = 4;
    localparam int XW = 5, YW = 3;
    localparam int NBEATS = IR * IC / BP;
`ifdef CROP_SUM_EN
    localparam int SW = 8 + $clog2(OR_ * OC + 1);
    logic [NC-1:0][SW-1:0] crop_sum;
`endif

    logic                  clk = 1'b0, reset = 1'b0, ap_start = 1'b0;
    logic                  ap_idle, ap_done;
    logic [NC-1:0]         crop_en = '0;
    logic [NC-1:0][XW-1:0] crop_x0 = '0;
    logic [NC-1:0][YW-1:0] crop_y0 = '0;
    logic [NC-1:0]         crop_err;

    rheed_multicrop_router_if #(.NUM_CROPS(NC), .BEAT_PIXELS(BP)) axis ();

    rheed_multicrop_router #(
        .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR_), .OUT_COLS(OC),
        .NUM_CROPS(NC), .BEAT_PIXELS(BP), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .ap_idle(ap_idle),
        .ap_done(ap_done), .crop_en(crop_en), .crop_x0(crop_x0),
        .crop_y0(crop_y0), .crop_err(crop_err), .axis(axis)
`ifdef CROP_SUM_EN
        , .crop_sum(crop_sum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame configuration and model state
    int          fx0 [NC], fy0 [NC];
    logic [NC-1:0] fen;
    logic [8:0]  exp_q [NC][$];
    logic [NC-1:0] exp_err = '0, exp_act = '0;
    int          exp_sum [NC];
    int          emitted [NC], first_pix [NC], tlast_pix [NC], tlast_cnt [NC];
    int          beats_acc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int          rmode = 0;
    bit          mon_en = 0, err_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int seed, input int r, input int c);
        return 8'((r * IC + c + seed) & 255);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected streams: every active crop yields its window in raster order.
    task automatic build_model(input int seed);
        err_valid = 0;
        for (int i = 0; i < NC; i++) begin
            exp_err[i] = (fx0[i] + OC > IC) || (fy0[i] + OR_ > IR);
            exp_act[i] = fen[i] && !exp_err[i];
            exp_q[i].delete();
            exp_sum[i] = 0;
            emitted[i] = 0; first_pix[i] = -1; tlast_pix[i] = -1; tlast_cnt[i] = 0;
            if (exp_act[i]) begin
                for (int r = fy0[i]; r < fy0[i] + OR_; r++)
                    for (int c = fx0[i]; c < fx0[i] + OC; c++) begin
                        exp_q[i].push_back({(r == fy0[i] + OR_ - 1) && (c == fx0[i] + OC - 1),
                                            pix(seed, r, c)});
                        exp_sum[i] += int'(pix(seed, r, c));
                    end
            end
        end
        beats_acc = 0;
        done_cnt  = 0;
    endtask

    // Sink ready patterns: 0 all ready, 1 crop0 ready one cycle in four, 2 random.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: axis.m_axis_tready = '1;
            1: begin
                axis.m_axis_tready    = '1;
                axis.m_axis_tready[0] = (cyc % 4 == 0);
            end
            default: axis.m_axis_tready = NC'($urandom);
        endcase
    end

    // Compare process
    logic [NC-1:0]      stall_v = '0;
    logic [NC-1:0][8:0] stall_d;
    always @(negedge clk) begin : mon
        logic [8:0] got, e;
        if (!reset) begin
            stall_v = '0;
        end else if (mon_en) begin
            if (axis.s_axis_tvalid && axis.s_axis_tready) beats_acc++;
            if (err_valid) chk("crop_err_hold", crop_err, exp_err);
            for (int i = 0; i < NC; i++) begin
                got = {axis.m_axis_tlast[i], axis.m_axis_tdata[i]};
                if (!exp_act[i]) chk("inactive_tvalid", axis.m_axis_tvalid[i], 0);
                if (stall_v[i]) begin
                    chk("stall_tvalid", axis.m_axis_tvalid[i], 1);
                    chk("stall_data", got, stall_d[i]);
                end
                stall_v[i] = axis.m_axis_tvalid[i] && !axis.m_axis_tready[i];
                stall_d[i] = got;
                if (axis.m_axis_tvalid[i] && axis.m_axis_tready[i]) begin
                    last_hs_cyc = cyc;
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        failures++;
                        $display("FAIL extra_pixel crop=%0d actual=%0d required=none", i, got[7:0]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (got !== e) begin
                            failures++;
                            $display("FAIL pixel crop=%0d actual=%0h required=%0h", i, got, e);
                        end
                        if (first_pix[i] < 0) first_pix[i] = int'(got[7:0]);
                        if (got[8]) begin
                            tlast_cnt[i]++;
                            tlast_pix[i] = int'(got[7:0]);
                        end
                        emitted[i]++;
                    end
                end
            end
            if (ap_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_drained", axis.m_axis_tvalid, 0);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_ap_idle", ap_idle, 1);
        chk("rst_ap_done", ap_done, 0);
        chk("rst_s_tready", axis.s_axis_tready, 0);
        chk("rst_m_tvalid", axis.m_axis_tvalid, 0);
        chk("rst_m_tlast", axis.m_axis_tlast, 0);
        chk("rst_crop_err", crop_err, 0);
    endtask

    // Runs one frame. abort_beats>0 returns right after that many beats;
    // extra_start pulses ap_start with different coordinates mid-RUN.
    task automatic run_frame(input int seed, input bit bubbles, input int abort_beats,
                             input bit extra_start);
        logic [8*BP-1:0] d;
        bit hs;
        int t;
        build_model(seed);
        chk("idle_before_start", ap_idle, 1);
        for (int i = 0; i < NC; i++) begin
            crop_x0[i] = XW'(fx0[i]);
            crop_y0[i] = YW'(fy0[i]);
        end
        crop_en  = fen;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        crop_x0  = {NC{XW'($urandom)}};
        crop_y0  = {NC{YW'($urandom)}};
        crop_en  = NC'($urandom);
        chk("run_not_idle", ap_idle, 0);
        chk("crop_err_latched", crop_err, exp_err);
        err_valid = 1;
        for (int b = 0; b < NBEATS; b++) begin
            if (abort_beats > 0 && b == abort_beats) return;
            if (bubbles && ($urandom % 3 == 0)) begin
                axis.s_axis_tvalid = 1'b0;
                step();
            end
            for (int k = 0; k < BP; k++)
                d[k*8 +: 8] = pix(seed, (b * BP + k) / IC, (b * BP + k) % IC);
            axis.s_axis_tvalid = 1'b1;
            axis.s_axis_tdata  = d;
            if (extra_start && b == 2) begin
                ap_start = 1'b1;
                crop_x0  = {NC{5'd31}};
                crop_y0  = '0;
                crop_en  = '1;
            end
            t = 0;
            do begin
                @(negedge clk);
                hs = axis.s_axis_tready;
                step();
                ap_start = 1'b0;
                t++;
            end while (!hs && t < 2000);
            if (!hs) begin
                chk("beat_timeout", 0, 1);
                break;
            end
        end
        // Keep offering a beat: it must not be accepted after the frame.
        axis.s_axis_tdata = '1;
        t = 0;
        while (done_cnt == 0 && t < 5000) begin
            step();
            t++;
        end
        axis.s_axis_tvalid = 1'b0;
        chk("done_seen", done_cnt, 1);
        chk("done_pulse_low", ap_done, 0);
        chk("idle_after_done", ap_idle, 1);
        chk("beats_accepted", beats_acc, NBEATS);
        for (int i = 0; i < NC; i++) begin
            chk("queue_drained", exp_q[i].size(), 0);
            chk("emitted", emitted[i], exp_act[i] ? OR_ * OC : 0);
            chk("tlast_count", tlast_cnt[i], exp_act[i] ? 1 : 0);
`ifdef CROP_SUM_EN
            chk("crop_sum", crop_sum[i], exp_act[i] ? exp_sum[i] : 0);
`endif
        end
    endtask

    initial begin
        axis.s_axis_tvalid = 1'b0;
        axis.s_axis_tdata  = '0;
        axis.m_axis_tready = '1;
        repeat (3) step();
        check_reset_outputs();
        reset = 1'b1;
        step();
        mon_en = 1;

        // Basic routing
        rmode = 0;
        fx0 = '{0, 10, 28}; fy0 = '{0, 2, 4}; fen = 3'b111;
        run_frame(0, 0, 0, 0);
        chk("basic_crop1_first", first_pix[1], 74);
        chk("basic_crop1_tlast", tlast_pix[1], 173);
        chk("basic_done_gap", done_cyc - last_hs_cyc, 2);
`ifdef CROP_SUM_EN
        chk("basic_sum0_literal", crop_sum[0], 792);
`endif

        // Backpressure on crop0
        rmode = 1;
        run_frame(0, 0, 0, 0);

        // Illegal and disabled crops
        rmode = 2;
        fx0 = '{0, 10, 30}; fy0 = '{0, 2, 4}; fen = 3'b101;
        run_frame(17, 1, 0, 0);
        chk("illegal_err_literal", exp_err, 3'b100);
        chk("illegal_crop0_count", emitted[0], 16);

        // Overlapping windows
        rmode = 0;
        fx0 = '{5, 5, 5}; fy0 = '{3, 3, 3}; fen = 3'b111;
        run_frame(0, 0, 0, 0);
        for (int i = 0; i < NC; i++) begin
            chk("overlap_first", first_pix[i], 101);
            chk("overlap_tlast", tlast_pix[i], 200);
        end

        // Reset mid-frame, then a frame with a stray mid-RUN ap_start
        rmode = 2;
        fx0 = '{0, 10, 28}; fy0 = '{0, 2, 4}; fen = 3'b111;
        run_frame(3, 0, 3, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        axis.s_axis_tvalid = 1'b0;
        err_valid = 0;
        exp_act   = '0;
        for (int i = 0; i < NC; i++) exp_q[i].delete();
        step();
        step();
        reset = 1'b1;
        step();
        check_reset_outputs();
        run_frame(9, 1, 0, 1);

        // Randomized frames
        for (int f = 0; f < 5; f++) begin
            rmode = 2;
            for (int i = 0; i < NC; i++) begin
                fx0[i] = $urandom_range(0, IC - 1);
                fy0[i] = $urandom_range(0, IR - 1);
            end
            fen = NC'($urandom);
            run_frame(int'($urandom_range(0, 255)), 1, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rheed_multicrop_router.md
Name: rheed_multicrop_router

Overview:
- Parametrised next-generation front end for RHEED crop inference.
- Accepts a Mono8 frame as wide AXI-Stream beats and serialises each beat to one pixel per cycle, tracking row and column.
- Routes each pixel to NUM_CROPS independent crop output streams. Each stream has its own FIFO, enable bit, window-legality check and end-of-window tlast.
- Replaces the fixed-width, fixed-crop-count AND-tree front end, and adds per-frame coordinate latching and a done/idle handshake that includes draining.

Parameters:
- IN_ROWS, 64, input frame rows.
- IN_COLS, 64, input frame columns; must be a multiple of BEAT_PIXELS.
- OUT_ROWS, 16, crop window rows.
- OUT_COLS, 16, crop window columns.
- NUM_CROPS, 5, number of crop channels (≥1).
- BEAT_PIXELS, 32, Mono8 pixels per input beat; input width = 8*BEAT_PIXELS.
- FIFO_DEPTH, 4, per-crop output FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  start-of-frame pulse; honoured only in IDLE.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse when a frame is fully routed and drained.
- crop_en  in  NUM_CROPS  per-crop enable; latched at ap_start.
- crop_x0  in  NUM_CROPS x clog2(IN_COLS)  window left column; latched at ap_start.
- crop_y0  in  NUM_CROPS x clog2(IN_ROWS)  window top row; latched at ap_start.
- crop_err  out  NUM_CROPS  window exceeds the frame; valid from the cycle after the accepted ap_start until the next one.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accept.
- s_axis_tdata  in  8*BEAT_PIXELS  pixels; bits [7:0] are the first (leftmost) pixel.
- m_axis_tvalid  out  NUM_CROPS  per-crop pixel valid.
- m_axis_tready  in  NUM_CROPS  per-crop ready.
- m_axis_tdata  out  NUM_CROPS x 8  per-crop pixel.
- m_axis_tlast  out  NUM_CROPS  last pixel of that crop's window.

Behaviour:
- Reset (reset=0, async):
  - State is IDLE; ap_idle=1.
  - ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast and crop_err are 0.
  - FIFOs are empty; row, col and pixel-index counters are 0.
  - A reset mid-frame discards all buffered data.
- FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - s_axis_tready=0.
  - ap_start=1 latches crop_en, crop_x0, crop_y0, computes crop_err, clears counters, goes to RUN.
  - ap_start in any other state is ignored.
- Window legality:
  - crop_err[i] = (x0+OUT_COLS > IN_COLS) or (y0+OUT_ROWS > IN_ROWS), computed at width +1 bit so no wrap.
  - A crop is active when crop_en[i]=1 and crop_err[i]=0.
  - Inactive crops hold m_axis_tvalid=0 for the whole frame and never stall.
- RUN, beat buffer:
  - One-beat holding register.
  - s_axis_tready=1 when the register is empty, or when its last pixel (index BEAT_PIXELS-1) advances this cycle (back-to-back beats with no bubble).
- RUN, pixel advance:
  - The current pixel is at (row, col).
  - hit[i] = active[i] and x0<=col<x0+OUT_COLS and y0<=row<y0+OUT_ROWS.
  - The pixel advances iff the beat is valid and no hit crop's FIFO is full.
  - On advance, the pixel is written to every hit FIFO, tagged tlast = (col==x0+OUT_COLS-1 and row==y0+OUT_ROWS-1).
  - Overlapping windows receive the same pixel in the same cycle.
- Counters:
  - col wraps IN_COLS-1 -> 0 with row+1.
  - On advancing (IN_ROWS-1, IN_COLS-1), go to DRAIN with s_axis_tready=0.
  - Extra beats after that are not accepted.
- FIFO:
  - Write at cycle N makes m_axis_tvalid visible at N+1.
  - Simultaneous read and write when full is not permitted (write is blocked by the full check).
  - Simultaneous read and write when non-full keeps the occupancy.
  - m_axis_tdata and m_axis_tlast are stable while tvalid=1 and tready=0.
- DRAIN: wait until all FIFOs are empty, then go to DONE.
- DONE: ap_done=1 for one cycle, then go to IDLE.
- Pixel count: each active crop emits exactly OUT_ROWS*OUT_COLS pixels per frame, in raster order, with exactly one tlast.

Optional Feature:
- Macro CROP_SUM_EN.
- When defined:
  - Adds output crop_sum, NUM_CROPS x (8+clog2(OUT_ROWS*OUT_COLS+1)).
  - Each sum accumulates the pixels written to that crop's FIFO during the frame.
  - Sums clear on the accepted ap_start and are final and stable from the ap_done pulse until the next start.
  - Sums are 0 for inactive crops.
- When undefined: the port and accumulators are absent; all other behaviour is identical.

Test Plan:
Common setup: IN 8x32, OUT 4x4, NUM_CROPS=3, BEAT_PIXELS=32, FIFO_DEPTH=4; pixel(r,c)=r*32+c.
- Basic routing:
  - Stimulus: crops (x0,y0)=(0,0),(10,2),(28,4), all enabled, ready always 1, 8 beats.
  - Required: crop1 emits 74,75,76,77,106..., with tlast on 173; each crop 16 pixels; ap_done 1 cycle after the last FIFO empties; s_axis_tready drops after beat 8.
- Backpressure:
  - Stimulus: crop0 m_axis_tready toggles 1-in-4, others held 1.
  - Required: no pixel lost or duplicated on any crop; s_axis_tready stalls while crop0's FIFO is full; all crops carry correct data.
- Illegal/disabled:
  - Stimulus: crop2 x0=30 (crop_err[2]=1), crop1 crop_en=0.
  - Required: crops 1 and 2 never assert tvalid; crop0 completes normally; ap_done still fires.
- Overlap:
  - Stimulus: all three crops at (5,3).
  - Required: identical 16-pixel streams starting at 101, tlast on 200.
- Reset/start robustness:
  - Stimulus: reset asserted after beat 3; then a second ap_start during RUN.
  - Required: after reset all outputs are 0 and ap_idle=1; the mid-RUN ap_start has no effect; a new frame completes correctly.
- CROP_SUM_EN:
  - Stimulus: crop0 at (0,0).
  - Required: crop_sum[0] = 0+1+2+3+32+33+34+35+64+65+66+67+96+97+98+99 = 792 at ap_done.
